// File: rtl/pipe_execute_stage_pkg.sv
// Shared Y86 encodings (icode/ifun/stat/register) and condition evaluation
// used by the execute stage and its ALU.
package pipe_execute_stage_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;
    localparam logic [3:0] ALU_SHL = 4'h4;
    localparam logic [3:0] ALU_SAR = 4'h5;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [3:0] {
        C_ALWAYS = 4'h0,
        C_LE     = 4'h1,
        C_L      = 4'h2,
        C_E      = 4'h3,
        C_NE     = 4'h4,
        C_GE     = 4'h5,
        C_G      = 4'h6
    } cond_e;

    // cc is {ZF,SF,OF}; unknown condition codes never fire
    function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
        logic zf_s, sf_s, of_s, r_s;
        {zf_s, sf_s, of_s} = cc;
        case (ifun)
            C_ALWAYS: r_s = 1'b1;
            C_LE:     r_s = (sf_s ^ of_s) | zf_s;
            C_L:      r_s = sf_s ^ of_s;
            C_E:      r_s = zf_s;
            C_NE:     r_s = ~zf_s;
            C_GE:     r_s = ~(sf_s ^ of_s);
            C_G:      r_s = ~(sf_s ^ of_s) & ~zf_s;
            default:  r_s = 1'b0;
        endcase
        return r_s;
    endfunction

endpackage

// File: rtl/pipe_execute_stage_alu.sv
// Y86 ALU: valE = b OP a with ZF/SF/OF; optional shl/sar extension.
// op_ok drops for an unsupported function, in which case valE is forced to 0.
module y86_alu
    import pipe_execute_stage_pkg::*;
#(
    parameter int W       = 64,
    parameter int EXT_OPS = 0
) (
    input  logic [3:0]   alufun,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] vale,
    output logic         zf,
    output logic         sf,
    output logic         of,
    output logic         op_ok
);

    localparam int SHW = $clog2(W);

    logic [W-1:0] res_s;
    logic         of_s;
    logic         ok_s;

    // Function decode and overflow detection from operand/result signs
    always_comb begin
        res_s = {W{1'b0}};
        of_s  = 1'b0;
        ok_s  = 1'b1;
        case (alufun)
            ALU_ADD: begin
                res_s = b + a;
                of_s  = (a[W-1] == b[W-1]) && (res_s[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                res_s = b - a;
                of_s  = (a[W-1] != b[W-1]) && (res_s[W-1] != b[W-1]);
            end
            ALU_AND: res_s = b & a;
            ALU_XOR: res_s = b ^ a;
            ALU_SHL: begin
                if (EXT_OPS != 0) begin
                    res_s = b << a[SHW-1:0];
                end else begin
                    ok_s = 1'b0;
                end
            end
            ALU_SAR: begin
                if (EXT_OPS != 0) begin
                    res_s = $signed(b) >>> a[SHW-1:0];
                end else begin
                    ok_s = 1'b0;
                end
            end
            default: ok_s = 1'b0;
        endcase
    end

    assign vale  = ok_s ? res_s : {W{1'b0}};
    assign zf    = (vale == {W{1'b0}});
    assign sf    = vale[W-1];
    assign of    = ok_s & of_s;
    assign op_ok = ok_s;

endmodule

// File: rtl/pipe_execute_stage.sv
// Y86 execute stage: operand selection, ALU, CC register, branch/cmov
// condition and the E->M pipeline register with stall/bubble control.
module pipe_execute_stage
    import pipe_execute_stage_pkg::*;
#(
    parameter int         W       = 64,
    parameter int         EXT_OPS = 0,
    parameter logic [2:0] RST_CC  = 3'b100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valC,
    input  logic [W-1:0] E_valA,
    input  logic [W-1:0] E_valB,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic [2:0]   E_stat,
    input  logic         M_stall,
    input  logic         M_bubble,
    input  logic         m_exc,
    input  logic         W_exc,
    output logic [W-1:0] e_valE,
    output logic [3:0]   e_dstE,
    output logic         e_Cnd,
    output logic [3:0]   M_icode,
    output logic         M_Cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM,
    output logic [2:0]   M_stat,
    output logic [2:0]   cc
);

    localparam logic [W-1:0] WORD_BYTES = W'(W / 8);

    logic [W-1:0] alu_a_s, alu_b_s, alu_vale_s;
    logic [3:0]   alufun_s;
    logic         zf_s, sf_s, of_s, op_ok_s;
    logic         invalid_op_s, set_cc_s, cnd_s;
    logic [3:0]   dste_s;
    logic [2:0]   stat_s;

    logic [2:0]   cc_r;
    logic [3:0]   m_icode_r, m_dste_r, m_dstm_r;
    logic         m_cnd_r;
    logic [W-1:0] m_vale_r, m_vala_r;
    logic [2:0]   m_stat_r;

    // ALU operand selection; stack ops step by one word in either direction
    always_comb begin
        case (E_icode)
            I_RRMOVQ, I_OPQ:              alu_a_s = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a_s = E_valC;
            I_CALL, I_PUSHQ:              alu_a_s = {W{1'b0}} - WORD_BYTES;
            I_RET, I_POPQ:                alu_a_s = WORD_BYTES;
            default:                      alu_a_s = {W{1'b0}};
        endcase
        if ((E_icode == I_RRMOVQ) || (E_icode == I_IRMOVQ)) begin
            alu_b_s = {W{1'b0}};
        end else begin
            alu_b_s = E_valB;
        end
        if (E_icode == I_OPQ) begin
            alufun_s = E_ifun;
        end else begin
            alufun_s = ALU_ADD;
        end
    end

    y86_alu #(
        .W       (W),
        .EXT_OPS (EXT_OPS)
    ) u_alu (
        .alufun (alufun_s),
        .a      (alu_a_s),
        .b      (alu_b_s),
        .vale   (alu_vale_s),
        .zf     (zf_s),
        .sf     (sf_s),
        .of     (of_s),
        .op_ok  (op_ok_s)
    );

    // Condition, cmov destination suppression, status and CC-write qualification
    always_comb begin
        invalid_op_s = (E_icode == I_OPQ) && !op_ok_s;
        if ((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) begin
            cnd_s = cond_eval(E_ifun, cc_r);
        end else begin
            cnd_s = 1'b0;
        end
        if ((E_icode == I_RRMOVQ) && !cnd_s) begin
            dste_s = REG_NONE;
        end else begin
            dste_s = E_dstE;
        end
        if (invalid_op_s) begin
            stat_s = STAT_INS;
        end else begin
            stat_s = E_stat;
        end
        set_cc_s = (E_icode == I_OPQ) && op_ok_s && (E_stat == STAT_AOK)
                   && !m_exc && !W_exc && !M_stall;
    end

    assign e_valE = alu_vale_s;
    assign e_dstE = dste_s;
    assign e_Cnd  = cnd_s;

    // Condition-code register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_r <= RST_CC;
        end else if (set_cc_s) begin
            cc_r <= {zf_s, sf_s, of_s};
        end else begin
            cc_r <= cc_r;
        end
    end

    // E->M pipeline register: bubble inserts a NOP, stall holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_icode_r <= I_NOP;
            m_cnd_r   <= 1'b0;
            m_vale_r  <= {W{1'b0}};
            m_vala_r  <= {W{1'b0}};
            m_dste_r  <= REG_NONE;
            m_dstm_r  <= REG_NONE;
            m_stat_r  <= STAT_AOK;
        end else if (M_bubble) begin
            m_icode_r <= I_NOP;
            m_cnd_r   <= 1'b0;
            m_vale_r  <= {W{1'b0}};
            m_vala_r  <= {W{1'b0}};
            m_dste_r  <= REG_NONE;
            m_dstm_r  <= REG_NONE;
            m_stat_r  <= STAT_AOK;
        end else if (M_stall) begin
            m_icode_r <= m_icode_r;
            m_cnd_r   <= m_cnd_r;
            m_vale_r  <= m_vale_r;
            m_vala_r  <= m_vala_r;
            m_dste_r  <= m_dste_r;
            m_dstm_r  <= m_dstm_r;
            m_stat_r  <= m_stat_r;
        end else begin
            m_icode_r <= E_icode;
            m_cnd_r   <= cnd_s;
            m_vale_r  <= alu_vale_s;
            m_vala_r  <= E_valA;
            m_dste_r  <= dste_s;
            m_dstm_r  <= E_dstM;
            m_stat_r  <= stat_s;
        end
    end

    assign cc      = cc_r;
    assign M_icode = m_icode_r;
    assign M_Cnd   = m_cnd_r;
    assign M_valE  = m_vale_r;
    assign M_valA  = m_vala_r;
    assign M_dstE  = m_dste_r;
    assign M_dstM  = m_dstm_r;
    assign M_stat  = m_stat_r;

endmodule

// File: tb/tb_pipe_execute_stage.sv
// Scoreboard bench: a 64-bit (shift extension on) and a 32-bit (extension off)
// execute stage share stimulus and are checked against an arithmetic model.
module tb_pipe_execute_stage;

    typedef struct {
        logic [3:0]  icode, ifun;
        logic [63:0] valc, vala, valb;
        logic [3:0]  dste, dstm;
        logic [2:0]  stat;
        logic        stall, bubble, mexc, wexc;
    } in_t;

    typedef struct {
        logic [63:0] vale;
        logic [3:0]  dste;
        logic        cnd;
    } ce_t;

    typedef struct {
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] vale, vala;
        logic [3:0]  dste, dstm;
        logic [2:0]  stat;
        logic [2:0]  cc;
    } st_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  icode = 4'h1, ifun = 4'h0, dste = 4'hF, dstm = 4'hF;
    logic [63:0] valc = 64'd0, vala = 64'd0, valb = 64'd0;
    logic [2:0]  stat = 3'd1;
    logic        stall = 1'b0, bubble = 1'b0, mexc = 1'b0, wexc = 1'b0;

    logic [63:0] e_vale64, m_vale64, m_vala64;
    logic [31:0] e_vale32, m_vale32, m_vala32;
    logic [3:0]  e_dste64, m_icode64, m_dste64, m_dstm64;
    logic [3:0]  e_dste32, m_icode32, m_dste32, m_dstm32;
    logic        e_cnd64, m_cnd64, e_cnd32, m_cnd32;
    logic [2:0]  m_stat64, cc64, m_stat32, cc32;

    int checks = 0;
    int failures = 0;

    ce_t qe0[$], qe1[$];
    st_t qm0[$], qm1[$];
    st_t st[2];

    always #5 clk = ~clk;

    pipe_execute_stage #(.W(64), .EXT_OPS(1)) dut64 (
        .clk(clk), .rst(rst), .E_icode(icode), .E_ifun(ifun),
        .E_valC(valc), .E_valA(vala), .E_valB(valb), .E_dstE(dste), .E_dstM(dstm),
        .E_stat(stat), .M_stall(stall), .M_bubble(bubble), .m_exc(mexc), .W_exc(wexc),
        .e_valE(e_vale64), .e_dstE(e_dste64), .e_Cnd(e_cnd64), .M_icode(m_icode64),
        .M_Cnd(m_cnd64), .M_valE(m_vale64), .M_valA(m_vala64), .M_dstE(m_dste64),
        .M_dstM(m_dstm64), .M_stat(m_stat64), .cc(cc64)
    );

    pipe_execute_stage #(.W(32), .EXT_OPS(0)) dut32 (
        .clk(clk), .rst(rst), .E_icode(icode), .E_ifun(ifun),
        .E_valC(valc[31:0]), .E_valA(vala[31:0]), .E_valB(valb[31:0]), .E_dstE(dste),
        .E_dstM(dstm), .E_stat(stat), .M_stall(stall), .M_bubble(bubble), .m_exc(mexc),
        .W_exc(wexc), .e_valE(e_vale32), .e_dstE(e_dste32), .e_Cnd(e_cnd32),
        .M_icode(m_icode32), .M_Cnd(m_cnd32), .M_valE(m_vale32), .M_valA(m_vala32),
        .M_dstE(m_dste32), .M_dstM(m_dstm32), .M_stat(m_stat32), .cc(cc32)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic st_t reset_state();
        st_t s;
        s.icode = 4'h1; s.cnd = 1'b0; s.vale = 64'd0; s.vala = 64'd0;
        s.dste = 4'hF; s.dstm = 4'hF; s.stat = 3'd1; s.cc = 3'b100;
        return s;
    endfunction

    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    // Two's-complement value of a w-bit pattern
    function automatic logic signed [65:0] sval(input int w, input logic [63:0] v);
        logic signed [65:0] x;
        x = $signed({2'b00, v});
        if (v[w-1]) x = x - (66'sd1 <<< w);
        return x;
    endfunction

    function automatic void alu_model(input int w, input bit ext, input logic [3:0] fun,
                                      input logic [63:0] a, input logic [63:0] b,
                                      output logic [63:0] r, output bit ok, output bit of);
        logic signed [65:0] s, mx, mn;
        int amt;
        mx  = (66'sd1 <<< (w - 1)) - 66'sd1;
        mn  = -(66'sd1 <<< (w - 1));
        amt = int'(a % 64'(w));
        ok = 1'b1; of = 1'b0; r = 64'd0;
        case (fun)
            4'd0: begin s = sval(w, b) + sval(w, a); r = s[63:0]; of = (s > mx) || (s < mn); end
            4'd1: begin s = sval(w, b) - sval(w, a); r = s[63:0]; of = (s > mx) || (s < mn); end
            4'd2: r = a & b;
            4'd3: r = a ^ b;
            4'd4: if (ext) r = b << amt; else ok = 1'b0;
            4'd5: if (ext) begin s = sval(w, b) >>> amt; r = s[63:0]; end else ok = 1'b0;
            default: ok = 1'b0;
        endcase
        r = ok ? (r & wmask(w)) : 64'd0;
    endfunction

    function automatic bit cond_model(input logic [3:0] f, input logic [2:0] c);
        bit zf, sf, of;
        zf = c[2]; sf = c[1]; of = c[0];
        case (f)
            4'd0: return 1'b1;
            4'd1: return (sf != of) || zf;
            4'd2: return sf != of;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return sf == of;
            4'd6: return (sf == of) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void step(input int w, input bit ext, input in_t x,
                                 inout st_t s, output ce_t e);
        logic [63:0] m, va, vb, vc, aa, bb, r;
        logic [3:0]  fun;
        bit ok, of, cnd;
        m = wmask(w);
        va = x.vala & m; vb = x.valb & m; vc = x.valc & m;
        case (x.icode)
            4'h2, 4'h6:       aa = va;
            4'h3, 4'h4, 4'h5: aa = vc;
            4'h8, 4'hA:       aa = (64'd0 - 64'(w / 8)) & m;
            4'h9, 4'hB:       aa = 64'(w / 8);
            default:          aa = 64'd0;
        endcase
        bb  = (x.icode == 4'h2 || x.icode == 4'h3) ? 64'd0 : vb;
        fun = (x.icode == 4'h6) ? x.ifun : 4'd0;
        alu_model(w, ext, fun, aa, bb, r, ok, of);
        cnd = (x.icode == 4'h2 || x.icode == 4'h7) ? cond_model(x.ifun, s.cc) : 1'b0;
        e.vale = r;
        e.cnd  = cnd;
        e.dste = (x.icode == 4'h2 && !cnd) ? 4'hF : x.dste;
        if (x.icode == 4'h6 && ok && x.stat == 3'd1 && !x.mexc && !x.wexc && !x.stall)
            s.cc = {r == 64'd0, r[w-1], of};
        if (x.bubble) begin
            s.icode = 4'h1; s.cnd = 1'b0; s.vale = 64'd0; s.vala = 64'd0;
            s.dste = 4'hF; s.dstm = 4'hF; s.stat = 3'd1;
        end else if (!x.stall) begin
            s.icode = x.icode; s.cnd = cnd; s.vale = r; s.vala = va;
            s.dste = e.dste; s.dstm = x.dstm;
            s.stat = (x.icode == 4'h6 && !ok) ? 3'd4 : x.stat;
        end
    endfunction

    task automatic issue(input in_t x);
        ce_t e0, e1;
        @(negedge clk); #1;
        icode = x.icode; ifun = x.ifun; valc = x.valc; vala = x.vala; valb = x.valb;
        dste = x.dste; dstm = x.dstm; stat = x.stat;
        stall = x.stall; bubble = x.bubble; mexc = x.mexc; wexc = x.wexc;
        step(64, 1'b1, x, st[0], e0);
        step(32, 1'b0, x, st[1], e1);
        qe0.push_back(e0); qe1.push_back(e1);
        qm0.push_back(st[0]); qm1.push_back(st[1]);
    endtask

    function automatic in_t mk(input logic [3:0] ic, input logic [3:0] fn,
                               input logic [63:0] a, input logic [63:0] b);
        in_t x;
        x.icode = ic; x.ifun = fn; x.valc = 64'h40; x.vala = a; x.valb = b;
        x.dste = 4'h3; x.dstm = 4'h5; x.stat = 3'd1;
        x.stall = 1'b0; x.bubble = 1'b0; x.mexc = 1'b0; x.wexc = 1'b0;
        return x;
    endfunction

    // Asynchronous reset between edges; outputs must clear before any clock
    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        st[0] = reset_state();
        st[1] = reset_state();
        chk("rst d64 cc", {61'd0, cc64}, {61'd0, st[0].cc});
        chk("rst d64 M_icode", {60'd0, m_icode64}, {60'd0, st[0].icode});
        chk("rst d64 M_stat", {61'd0, m_stat64}, {61'd0, st[0].stat});
        chk("rst d64 M_dstE", {60'd0, m_dste64}, {60'd0, st[0].dste});
        chk("rst d64 M_dstM", {60'd0, m_dstm64}, {60'd0, st[0].dstm});
        chk("rst d64 M_valE", m_vale64, st[0].vale);
        chk("rst d64 M_valA", m_vala64, st[0].vala);
        chk("rst d64 M_Cnd", {63'd0, m_cnd64}, {63'd0, st[0].cnd});
        chk("rst d32 cc", {61'd0, cc32}, {61'd0, st[1].cc});
        chk("rst d32 M_icode", {60'd0, m_icode32}, {60'd0, st[1].icode});
        chk("rst d32 M_dstE", {60'd0, m_dste32}, {60'd0, st[1].dste});
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic logic [63:0] rv();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'h0000_0000_7FFF_FFFF;
            5: return 64'h0000_0000_8000_0000;
            6: return 64'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic in_t rnd();
        in_t x;
        x = mk(4'($urandom_range(0, 11)), 4'($urandom_range(0, 7)), rv(), rv());
        x.valc   = rv();
        x.dste   = 4'($urandom_range(0, 15));
        x.dstm   = 4'($urandom_range(0, 15));
        x.stat   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
        x.stall  = ($urandom_range(0, 9) == 0);
        x.bubble = ($urandom_range(0, 11) == 0);
        x.mexc   = ($urandom_range(0, 11) == 0);
        x.wexc   = ($urandom_range(0, 11) == 0);
        return x;
    endfunction

    // Monitor: combinational outputs just before each edge, registers just after
    initial begin
        ce_t e;
        st_t s;
        forever begin
            @(negedge clk); #4;
            if (qe0.size() > 0) begin
                e = qe0.pop_front();
                chk("d64 e_valE", e_vale64, e.vale);
                chk("d64 e_dstE", {60'd0, e_dste64}, {60'd0, e.dste});
                chk("d64 e_Cnd", {63'd0, e_cnd64}, {63'd0, e.cnd});
            end
            if (qe1.size() > 0) begin
                e = qe1.pop_front();
                chk("d32 e_valE", {32'd0, e_vale32}, e.vale);
                chk("d32 e_dstE", {60'd0, e_dste32}, {60'd0, e.dste});
                chk("d32 e_Cnd", {63'd0, e_cnd32}, {63'd0, e.cnd});
            end
            @(posedge clk); #1;
            if (qm0.size() > 0) begin
                s = qm0.pop_front();
                chk("d64 cc", {61'd0, cc64}, {61'd0, s.cc});
                chk("d64 M_icode", {60'd0, m_icode64}, {60'd0, s.icode});
                chk("d64 M_Cnd", {63'd0, m_cnd64}, {63'd0, s.cnd});
                chk("d64 M_valE", m_vale64, s.vale);
                chk("d64 M_valA", m_vala64, s.vala);
                chk("d64 M_dstE", {60'd0, m_dste64}, {60'd0, s.dste});
                chk("d64 M_dstM", {60'd0, m_dstm64}, {60'd0, s.dstm});
                chk("d64 M_stat", {61'd0, m_stat64}, {61'd0, s.stat});
            end
            if (qm1.size() > 0) begin
                s = qm1.pop_front();
                chk("d32 cc", {61'd0, cc32}, {61'd0, s.cc});
                chk("d32 M_icode", {60'd0, m_icode32}, {60'd0, s.icode});
                chk("d32 M_Cnd", {63'd0, m_cnd32}, {63'd0, s.cnd});
                chk("d32 M_valE", {32'd0, m_vale32}, s.vale);
                chk("d32 M_valA", {32'd0, m_vala32}, s.vala);
                chk("d32 M_dstE", {60'd0, m_dste32}, {60'd0, s.dste});
                chk("d32 M_dstM", {60'd0, m_dstm32}, {60'd0, s.dstm});
                chk("d32 M_stat", {61'd0, m_stat32}, {61'd0, s.stat});
            end
        end
    end

    initial begin
        in_t x;
        do_reset();
        issue(mk(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF));
        issue(mk(4'h6, 4'h1, 64'd5, 64'd5));
        issue(mk(4'h7, 4'h3, 64'd0, 64'd0));
        issue(mk(4'h7, 4'h4, 64'd0, 64'd0));
        issue(mk(4'h2, 4'h1, 64'h1234, 64'd0));
        issue(mk(4'h2, 4'h6, 64'h1234, 64'd0));
        x = mk(4'h6, 4'h0, 64'd3, 64'd4); x.mexc = 1'b1; issue(x);
        x = mk(4'h6, 4'h1, 64'd9, 64'd4); x.wexc = 1'b1; issue(x);
        x = mk(4'h6, 4'h3, 64'hFF, 64'h0F); x.stall = 1'b1; issue(x); issue(x);
        x.bubble = 1'b1; issue(x);
        issue(mk(4'hA, 4'h0, 64'd0, 64'h100));
        issue(mk(4'hB, 4'h0, 64'd0, 64'h100));
        issue(mk(4'h8, 4'h0, 64'd0, 64'h200));
        issue(mk(4'h9, 4'h0, 64'd0, 64'h200));
        issue(mk(4'h6, 4'h5, 64'd4, 64'h8000_0000_0000_0000));
        issue(mk(4'h6, 4'h4, 64'd63, 64'd1));
        issue(mk(4'h6, 4'h7, 64'd1, 64'd1));
        issue(mk(4'h6, 4'h2, 64'hF0F0, 64'h0FF0));
        for (int i = 0; i < 300; i++) issue(rnd());
        do_reset();
        for (int i = 0; i < 150; i++) issue(rnd());
        @(posedge clk); @(posedge clk); #2;
        chk("scoreboard drained", 64'(qm0.size() + qm1.size() + qe0.size() + qe1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
